spu_write_checker: RTL and testbench

//  Self-checking memory-write monitor for cellspu system benches. Snoops the core's

---
 rtl/spu_write_checker.sv | 139 +++++++++++++
 tb/tb_spu_write_checker.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spu_write_checker.sv
// Memory-write monitor: checks snooped core data-memory writes, in order, against a
// programmed table of expected {adr, data, mask} entries and reports pass/fail.
module spu_write_checker #(
    parameter int unsigned RFWIDTH = 128,
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned IDXBITS = 3,
    parameter int unsigned TOBITS  = 16,
    parameter int unsigned TIMEOUT = 1000,
    parameter bit          STRICT  = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_we,
    input  logic [IDXBITS-1:0] cfg_idx,
    input  logic [WIDTH-1:0]   cfg_adr,
    input  logic [RFWIDTH-1:0] cfg_data,
    input  logic [RFWIDTH-1:0] cfg_mask,
    input  logic [IDXBITS:0]   num_exp,
    input  logic               start,
    input  logic               memwrite,
    input  logic [WIDTH-1:0]   adr,
    input  logic [RFWIDTH-1:0] writedata,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic               fail,
    output logic [1:0]         fail_code,
    output logic [IDXBITS-1:0] err_idx,
    output logic [WIDTH-1:0]   err_adr,
    output logic [RFWIDTH-1:0] err_data,
    output logic [IDXBITS:0]   match_cnt
);

    localparam int unsigned        DEPTH    = 2 ** IDXBITS;
    localparam logic [IDXBITS:0]   DEPTH_N  = (IDXBITS + 1)'(DEPTH);
    localparam logic [IDXBITS:0]   N_ONE    = (IDXBITS + 1)'(1);
    localparam logic [IDXBITS-1:0] P_ONE    = IDXBITS'(1);
    localparam logic [TOBITS-1:0]  WD_ONE   = TOBITS'(1);
    localparam logic [TOBITS-1:0]  WD_LIMIT = TOBITS'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StRun, StPass, StFail} state_e;

    state_e             state;
    logic [IDXBITS-1:0] ptr;
    logic [IDXBITS:0]   n;
    logic [TOBITS-1:0]  wd;

    logic [WIDTH-1:0]   tab_adr  [DEPTH];
    logic [RFWIDTH-1:0] tab_data [DEPTH];
    logic [RFWIDTH-1:0] tab_mask [DEPTH];

    logic [IDXBITS:0]   n_start;
    logic               hit;
    logic               last;

    // Table is deliberately not reset so a harness can re-arm after reset without reloading.
    always_ff @(posedge clk) begin
        if (cfg_we && state != StRun) begin
            tab_adr[cfg_idx]  <= cfg_adr;
            tab_data[cfg_idx] <= cfg_data;
            tab_mask[cfg_idx] <= cfg_mask;
        end
    end

    always_comb begin
        n_start = (num_exp > DEPTH_N) ? DEPTH_N : num_exp;
        hit     = memwrite && (adr == tab_adr[ptr]) &&
                  (((writedata ^ tab_data[ptr]) & tab_mask[ptr]) == '0);
        last    = ({1'b0, ptr} == (n - N_ONE));
    end

    assign busy = (state == StRun);
    assign done = (state == StPass) || (state == StFail);
    assign pass = (state == StPass);
    assign fail = (state == StFail);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= StIdle;
            ptr       <= '0;
            n         <= '0;
            wd        <= '0;
            fail_code <= '0;
            err_idx   <= '0;
            err_adr   <= '0;
            err_data  <= '0;
            match_cnt <= '0;
        end else begin
            unique case (state)
                StRun: begin
                    // A hit on the timeout cycle still counts as progress.
                    if (hit) begin
                        match_cnt <= match_cnt + N_ONE;
                        wd        <= '0;
                        if (last) begin
                            state <= StPass;
                        end else begin
                            ptr <= ptr + P_ONE;
                        end
                    end else if (memwrite && STRICT) begin
                        state     <= StFail;
                        fail_code <= 2'd1;
                        err_idx   <= ptr;
                        err_adr   <= adr;
                        err_data  <= writedata;
                    end else if (wd == WD_LIMIT) begin
                        state     <= StFail;
                        fail_code <= 2'd2;
                        err_idx   <= ptr;
                        err_adr   <= '0;
                        err_data  <= '0;
                    end else begin
                        wd <= wd + WD_ONE;
                    end
                end
                StIdle, StPass, StFail: begin
                    if (start) begin
                        n         <= n_start;
                        ptr       <= '0;
                        wd        <= '0;
                        match_cnt <= '0;
                        fail_code <= '0;
                        err_idx   <= '0;
                        err_adr   <= '0;
                        err_data  <= '0;
                        state     <= (n_start == '0) ? StPass : StRun;
                    end else if (state == StPass && STRICT && memwrite) begin
                        state     <= StFail;
                        fail_code <= 2'd3;
                        err_idx   <= IDXBITS'(n - N_ONE);
                        err_adr   <= adr;
                        err_data  <= writedata;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spu_write_checker.sv
// Bench for spu_write_checker: a strict and a lenient instance share stimulus and are
// compared every cycle against an in-order expected-write queue model.
module tb_spu_write_checker;

    localparam int TMO = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         cfg_we, start, memwrite;
    logic [2:0]   cfg_idx;
    logic [31:0]  cfg_adr, adr;
    logic [127:0] cfg_data, cfg_mask, writedata;
    logic [3:0]   num_exp;

    logic         s_busy, s_done, s_pass, s_fail, l_busy, l_done, l_pass, l_fail;
    logic [1:0]   s_code, l_code;
    logic [2:0]   s_eidx, l_eidx;
    logic [31:0]  s_eadr, l_eadr;
    logic [127:0] s_edat, l_edat;
    logic [3:0]   s_mcnt, l_mcnt;

    always #5 clk = ~clk;

    spu_write_checker #(.RFWIDTH(128), .WIDTH(32), .IDXBITS(3), .TOBITS(16), .TIMEOUT(TMO),
                        .STRICT(1'b1)) dut_s (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_adr(cfg_adr),
        .cfg_data(cfg_data), .cfg_mask(cfg_mask), .num_exp(num_exp), .start(start),
        .memwrite(memwrite), .adr(adr), .writedata(writedata), .busy(s_busy), .done(s_done),
        .pass(s_pass), .fail(s_fail), .fail_code(s_code), .err_idx(s_eidx), .err_adr(s_eadr),
        .err_data(s_edat), .match_cnt(s_mcnt));

    spu_write_checker #(.RFWIDTH(128), .WIDTH(32), .IDXBITS(3), .TOBITS(16), .TIMEOUT(TMO),
                        .STRICT(1'b0)) dut_l (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_adr(cfg_adr),
        .cfg_data(cfg_data), .cfg_mask(cfg_mask), .num_exp(num_exp), .start(start),
        .memwrite(memwrite), .adr(adr), .writedata(writedata), .busy(l_busy), .done(l_done),
        .pass(l_pass), .fail(l_fail), .fail_code(l_code), .err_idx(l_eidx), .err_adr(l_eadr),
        .err_data(l_edat), .match_cnt(l_mcnt));

    // Reference model, index 0 = strict instance, 1 = lenient instance.
    logic [31:0]  mt_adr  [2][8];
    logic [127:0] mt_data [2][8];
    logic [127:0] mt_mask [2][8];
    bit           armed [2], finished [2], okm [2];
    int           code [2], eidx [2], matched [2], want [2], quiet [2];
    logic [31:0]  eadr [2];
    logic [127:0] edat [2];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            armed[m] = 0; finished[m] = 0; okm[m] = 0; code[m] = 0; eidx[m] = 0;
            eadr[m] = '0; edat[m] = '0; matched[m] = 0; want[m] = 0; quiet[m] = 0;
        end
    endtask

    task automatic model_fail(input int m, input int c, input int idx, input logic [31:0] a,
                              input logic [127:0] d);
        armed[m] = 0; finished[m] = 1; okm[m] = 0;
        code[m] = c; eidx[m] = idx; eadr[m] = a; edat[m] = d;
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        for (int m = 0; m < 2; m++) begin
            bit strict;
            bit was_armed;
            bit hit;
            int k;
            strict    = (m == 0);
            was_armed = armed[m];
            hit       = 0;
            if (cfg_we && !was_armed) begin
                mt_adr[m][cfg_idx]  = cfg_adr;
                mt_data[m][cfg_idx] = cfg_data;
                mt_mask[m][cfg_idx] = cfg_mask;
            end
            if (was_armed && memwrite) begin
                k   = matched[m];
                hit = (adr == mt_adr[m][k]) &&
                      (((writedata ^ mt_data[m][k]) & mt_mask[m][k]) == '0);
            end
            if (!was_armed && start) begin
                want[m] = (num_exp > 8) ? 8 : int'(num_exp);
                matched[m] = 0; quiet[m] = 0; code[m] = 0; eidx[m] = 0;
                eadr[m] = '0; edat[m] = '0;
                armed[m] = (want[m] != 0); finished[m] = (want[m] == 0); okm[m] = (want[m] == 0);
            end else if (was_armed) begin
                if (hit) begin
                    matched[m]++;
                    quiet[m] = 0;
                    if (matched[m] == want[m]) begin
                        armed[m] = 0; finished[m] = 1; okm[m] = 1;
                    end
                end else if (memwrite && strict) begin
                    model_fail(m, 1, matched[m], adr, writedata);
                end else if (quiet[m] == TMO - 1) begin
                    model_fail(m, 2, matched[m], '0, '0);
                end else begin
                    quiet[m]++;
                end
            end else if (finished[m] && okm[m] && strict && memwrite) begin
                model_fail(m, 3, want[m] - 1, adr, writedata);
            end
        end
    endtask

    task automatic check_inst(input string tag, input int m, input logic b, input logic dn,
                              input logic p, input logic f, input logic [1:0] c,
                              input logic [2:0] ei, input logic [31:0] ea,
                              input logic [127:0] ed, input logic [3:0] mc);
        chk({tag, ".busy"}, 128'(b), 128'(armed[m]));
        chk({tag, ".done"}, 128'(dn), 128'(finished[m]));
        chk({tag, ".pass"}, 128'(p), 128'(finished[m] && okm[m]));
        chk({tag, ".fail"}, 128'(f), 128'(finished[m] && !okm[m]));
        chk({tag, ".fail_code"}, 128'(c), 128'(code[m]));
        chk({tag, ".err_idx"}, 128'(ei), 128'(eidx[m] & 7));
        chk({tag, ".err_adr"}, 128'(ea), 128'(eadr[m]));
        chk({tag, ".err_data"}, ed, edat[m]);
        chk({tag, ".match_cnt"}, 128'(mc), 128'(matched[m]));
    endtask

    task automatic check_all(input string tag);
        check_inst({tag, ".s"}, 0, s_busy, s_done, s_pass, s_fail, s_code, s_eidx, s_eadr,
                   s_edat, s_mcnt);
        check_inst({tag, ".l"}, 1, l_busy, l_done, l_pass, l_fail, l_code, l_eidx, l_eadr,
                   l_edat, l_mcnt);
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic set_idle();
        cfg_we = 0; start = 0; memwrite = 0;
    endtask

    task automatic cfg(input int idx, input logic [31:0] a, input logic [127:0] d,
                       input logic [127:0] msk);
        cfg_we = 1; cfg_idx = 3'(idx); cfg_adr = a; cfg_data = d; cfg_mask = msk;
        tick("cfg");
        cfg_we = 0;
    endtask

    task automatic go(input int n);
        num_exp = 4'(n); start = 1;
        tick("start");
        start = 0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [127:0] d);
        memwrite = 1; adr = a; writedata = d;
        tick("write");
        memwrite = 0;
    endtask

    task automatic do_reset();
        set_idle();
        reset = 0;
        #1;
        model_reset();
        check_all("reset_async");
        @(posedge clk);
        #1;
        check_all("reset_held");
        reset = 1;
    endtask

    localparam logic [127:0] ONES = '1;

    initial begin
        logic [127:0] rd, rm;
        int           act, k;
        set_idle();
        cfg_idx = '0; cfg_adr = '0; cfg_data = '0; cfg_mask = '0; num_exp = '0;
        adr = '0; writedata = '0;
        reset = 0;
        #1;
        model_reset();
        check_all("por");
        @(posedge clk);
        #1;
        reset = 1;

        for (int i = 0; i < 8; i++) begin
            rd = {$urandom(), $urandom(), $urandom(), $urandom()};
            cfg(i, 32'h100 + 32'(i), rd, ONES);
        end

        // Single matching write.
        cfg(0, 32'd5, 128'd7, ONES);
        go(1);
        wr(32'd5, 128'd7);
        chk("t1_pass", 128'(s_pass), 128'd1);
        chk("t1_match_cnt", 128'(s_mcnt), 128'd1);
        chk("t1_fail_code", 128'(s_code), 128'd0);

        // Data mismatch; lenient instance ignores it and later times out.
        go(1);
        wr(32'd5, 128'd8);
        chk("t2_fail", 128'(s_fail), 128'd1);
        chk("t2_fail_code", 128'(s_code), 128'd1);
        chk("t2_err_adr", 128'(s_eadr), 128'd5);
        chk("t2_err_data", s_edat, 128'd8);
        chk("t2_lenient_busy", 128'(l_busy), 128'd1);
        repeat (16) tick("t2_drain");

        // Watchdog fires exactly TMO cycles after start.
        go(1);
        repeat (TMO - 1) tick("t3_wait");
        chk("t3_no_early_fail", 128'(s_fail), 128'd0);
        tick("t3_expire");
        chk("t3_fail", 128'(s_fail), 128'd1);
        chk("t3_fail_code", 128'(s_code), 128'd2);
        chk("t3_err_adr", 128'(s_eadr), 128'd0);

        // Interleaved stray writes.
        cfg(0, 32'd5, 128'd7, ONES);
        cfg(1, 32'd6, 128'd9, ONES);
        go(2);
        wr(32'd3, 128'd1);
        wr(32'd5, 128'd7);
        wr(32'd4, 128'd4);
        wr(32'd6, 128'd9);
        chk("t4_lenient_pass", 128'(l_pass), 128'd1);
        chk("t4_lenient_match", 128'(l_mcnt), 128'd2);
        chk("t4_strict_code", 128'(s_code), 128'd1);
        chk("t4_strict_err_adr", 128'(s_eadr), 128'd3);

        // Masked compare, then a write after pass.
        cfg(0, 32'd5, 128'd7, 128'hFFFF_FFFF);
        go(1);
        wr(32'd5, {96'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA, 32'd7});
        chk("t5_pass", 128'(s_pass), 128'd1);
        wr(32'd9, 128'd3);
        chk("t5_after_pass_code", 128'(s_code), 128'd3);
        chk("t5_lenient_still_pass", 128'(l_pass), 128'd1);

        // Reset mid-run, then re-arm with the preserved table.
        cfg(0, 32'd10, 128'hA0, ONES);
        cfg(1, 32'd11, 128'hB1, ONES);
        cfg(2, 32'd12, 128'hC2, ONES);
        go(3);
        wr(32'd10, 128'hA0);
        chk("t6_one_match", 128'(s_mcnt), 128'd1);
        do_reset();
        chk("t6_reset_busy", 128'(s_busy), 128'd0);
        go(3);
        wr(32'd10, 128'hA0);
        wr(32'd11, 128'hB1);
        wr(32'd12, 128'hC2);
        chk("t6_pass", 128'(s_pass), 128'd1);
        chk("t6_match_cnt", 128'(s_mcnt), 128'd3);

        // Randomised traffic: writes are biased toward the strict instance's next entry.
        for (int it = 0; it < 600; it++) begin
            act = $urandom_range(0, 19);
            rd  = {$urandom(), $urandom(), $urandom(), $urandom()};
            if (act < 3) begin
                rm = ($urandom_range(0, 1) == 0) ? ONES : {$urandom(), $urandom(), $urandom(),
                                                           $urandom()};
                cfg($urandom_range(0, 7), 32'($urandom_range(0, 15)), rd, rm);
            end else if (act < 5) begin
                memwrite = ($urandom_range(0, 3) == 0);
                adr = 32'($urandom_range(0, 15));
                writedata = rd;
                go($urandom_range(0, 15));
                memwrite = 0;
            end else if (act < 15) begin
                k = matched[0] % 8;
                if ($urandom_range(0, 4) != 0) begin
                    wr(mt_adr[0][k], mt_data[0][k] ^ (rd & ~mt_mask[0][k]));
                end else begin
                    wr(32'($urandom_range(0, 15)), rd);
                end
            end else if (act < 19 || it % 7 != 0) begin
                tick("rand_idle");
            end else begin
                do_reset();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
